// File: rtl/delay_probe_pkg.sv
// Shared types and defaults for the delay_probe measurement block.
// Holds the FSM state encoding, default marker/timeout values and a counter-width helper.
package delay_probe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SEND,
    WAIT,
    REPORT
  } state_e;

  localparam logic [7:0]  DEFAULT_PATTERN  = 8'hA5;
  localparam int unsigned DEFAULT_MAX_WAIT = 15;

  // Bits needed to hold values 0..maxCount without wrapping
  function automatic int unsigned cntWidth(input int unsigned maxCount);
    return (maxCount < 2) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/delay_probe.sv
// Measures the latency of an external delay line by injecting a marker
// and counting edges until it returns on echo_in.
module delay_probe
  import delay_probe_pkg::*;
#(
  parameter logic [7:0]  PATTERN  = DEFAULT_PATTERN,
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] probe_out,
  input  logic [7:0] echo_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] delay,
  output logic       timeout
);

  localparam int unsigned         CNT_W   = cntWidth(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]    LAST    = MAX_WAIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0]    CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       probe_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       delay_q;
  logic             timeout_q;

  // cnt_q in SEND/WAIT holds E-1, so a match records cnt_q directly as the delay
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      probe_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      delay_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      probe_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_q == LAST) begin
            state_q <= SEND;
            cnt_q   <= '0;
            probe_q <= PATTERN;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        SEND, WAIT: begin
          if (echo_in == PATTERN) begin
            state_q   <= REPORT;
            delay_q   <= 8'(cnt_q);
            timeout_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (cnt_q == LAST) begin
            state_q   <= REPORT;
            delay_q   <= 8'hFF;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            state_q <= WAIT;
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        REPORT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign probe_out = probe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign delay     = delay_q;
  assign timeout   = timeout_q;

endmodule
